// File: rtl/picobus_arbiter_pkg.sv
// picobus_arbiter_pkg: shared PicoBus widths and arbiter FSM state encodings
package picobus_arbiter_pkg;
  localparam int PICOBUS_DATA_W = 32;
  localparam int PICOBUS_ADDR_W = 32;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;
endpackage

// File: rtl/picobus_rr_select.sv
// picobus_rr_select: round-robin pick of the first request at or after the pointer
module picobus_rr_select #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 3
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [PTR_W-1:0]   o_grant,
  output logic               o_any
);
  assign o_any = |i_req;
  // Lowest set request overall is the wrap-around fallback; the lowest one at or above the pointer overrides it
  always_comb begin
    o_grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) o_grant = i_req[i] ? PTR_W'(i) : o_grant;
    for (int i = NUM_REQ - 1; i >= 0; i--) o_grant = (i_req[i] && PTR_W'(i) >= i_ptr) ? PTR_W'(i) : o_grant;
  end
endmodule

// File: rtl/picobus_arbiter.sv
// picobus_arbiter: round-robin PicoBus master sharing single-beat reads/writes between requesters
module picobus_arbiter
  import picobus_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int READ_LATENCY = 1,
  parameter int PTR_W        = 3
) (
  input  logic                                PicoClk,
  input  logic                                PicoRst,
  input  logic [NUM_REQ-1:0]                  ReqValid,
  input  logic [NUM_REQ-1:0]                  ReqWrite,
  input  logic [PICOBUS_ADDR_W*NUM_REQ-1:0]   ReqAddr,
  input  logic [PICOBUS_DATA_W*NUM_REQ-1:0]   ReqData,
  output logic [NUM_REQ-1:0]                  ReqAck,
  output logic [NUM_REQ-1:0]                  RspValid,
  output logic [PICOBUS_DATA_W-1:0]           RspData,
  output logic [PICOBUS_ADDR_W-1:0]           PicoAddr,
  output logic [PICOBUS_DATA_W-1:0]           PicoDataOut,
  output logic                                PicoRd,
  output logic                                PicoWr,
  input  logic [PICOBUS_DATA_W-1:0]           PicoDataIn
);
  localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int SLOTS = 2 ** PTR_W;
  logic [1:0]                r_state;
  logic [PTR_W-1:0]          r_ptr;
  logic [PTR_W-1:0]          r_grant;
  logic [PICOBUS_ADDR_W-1:0] r_addr;
  logic [PICOBUS_DATA_W-1:0] r_data;
  logic [PICOBUS_DATA_W-1:0] r_rsp_data;
  logic                      r_write;
  logic [CNT_W-1:0]          r_cnt;
  logic [PTR_W-1:0]          w_grant;
  logic                      w_any;
  logic                      w_issue;
  logic                      w_wait;
  logic [PICOBUS_ADDR_W-1:0] w_addr_a  [SLOTS];
  logic [PICOBUS_DATA_W-1:0] w_data_a  [SLOTS];
  logic                      w_write_a [SLOTS];
  // Unflatten requester buses into pointer-indexed tables; slots past NUM_REQ read as zero
  for (genvar g = 0; g < SLOTS; g++) begin : gen_slot
    if (g < NUM_REQ) begin : gen_req
      assign w_addr_a[g]  = ReqAddr[PICOBUS_ADDR_W*g +: PICOBUS_ADDR_W];
      assign w_data_a[g]  = ReqData[PICOBUS_DATA_W*g +: PICOBUS_DATA_W];
      assign w_write_a[g] = ReqWrite[g];
    end else begin : gen_pad
      assign w_addr_a[g]  = '0;
      assign w_data_a[g]  = '0;
      assign w_write_a[g] = 1'b0;
    end
  end
  picobus_rr_select #(
    .NUM_REQ(NUM_REQ),
    .PTR_W  (PTR_W)
  ) u_sel (
    .i_req  (ReqValid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_any  (w_any)
  );
  assign w_issue     = r_state == ST_ISSUE;
  assign w_wait      = r_state == ST_WAIT;
  assign PicoAddr    = (w_issue || w_wait) ? r_addr : '0;
  assign PicoDataOut = (w_issue && r_write) ? r_data : '0;
  assign PicoRd      = w_issue && !r_write;
  assign PicoWr      = w_issue && r_write;
  assign ReqAck      = w_issue ? NUM_REQ'(1) << r_grant : '0;
  assign RspValid    = (r_state == ST_RESP) ? NUM_REQ'(1) << r_grant : '0;
  assign RspData     = r_rsp_data;
  // Transaction FSM: latch a grant, strobe once, wait out the read latency, return data
  always_ff @(posedge PicoClk or posedge PicoRst) begin
    if (PicoRst) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_grant    <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_write    <= 1'b0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_any) begin
        r_grant <= w_grant;
        r_addr  <= w_addr_a[w_grant];
        r_data  <= w_data_a[w_grant];
        r_write <= w_write_a[w_grant];
        r_state <= ST_ISSUE;
      end
    end else if (w_issue) begin
      r_ptr   <= (r_grant == PTR_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
      r_cnt   <= '0;
      r_state <= r_write ? ST_IDLE : ST_WAIT;
    end else if (w_wait) begin
      if (r_cnt == CNT_W'(READ_LATENCY - 1)) begin
        r_rsp_data <= PicoDataIn;
        r_state    <= ST_RESP;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else begin
      r_state <= ST_IDLE;
    end
  end
endmodule

// File: tb/tb_picobus_arbiter.sv
// tb_picobus_arbiter: directed checks of grant order, bus strobes, read latency and reset
module tb_picobus_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0, req_write = '0;
  logic [63:0] req_addr = '0, req_data = '0;
  logic [1:0]  ack, rsp_valid;
  logic [31:0] rsp_data, addr, dout, din;
  logic        rd, wr;
  logic [1:0]  req_valid3 = '0;
  logic [1:0]  ack3, rsp_valid3;
  logic [31:0] rsp_data3, addr3, dout3, din3;
  logic        rd3, wr3;
  logic [31:0] sd = '0, s1 = '0, s2 = '0, s3 = '0;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  picobus_arbiter #(.NUM_REQ(2), .READ_LATENCY(1), .PTR_W(3)) u_dut (
    .PicoClk(clk), .PicoRst(rst), .ReqValid(req_valid), .ReqWrite(req_write),
    .ReqAddr(req_addr), .ReqData(req_data), .ReqAck(ack), .RspValid(rsp_valid),
    .RspData(rsp_data), .PicoAddr(addr), .PicoDataOut(dout), .PicoRd(rd),
    .PicoWr(wr), .PicoDataIn(din)
  );
  picobus_arbiter #(.NUM_REQ(2), .READ_LATENCY(3), .PTR_W(3)) u_dut3 (
    .PicoClk(clk), .PicoRst(rst), .ReqValid(req_valid3), .ReqWrite(2'b00),
    .ReqAddr({32'h0, 32'h40}), .ReqData(64'h0), .ReqAck(ack3), .RspValid(rsp_valid3),
    .RspData(rsp_data3), .PicoAddr(addr3), .PicoDataOut(dout3), .PicoRd(rd3),
    .PicoWr(wr3), .PicoDataIn(din3)
  );
  // Latency-1 slave: registered read data, zero when not addressed
  always @(posedge clk)
    sd <= !rd ? 32'h0 : (addr == 32'h10) ? 32'hCAFE0001 : (addr == 32'h14) ? 32'hCAFE0014 : 32'h0;
  assign din = sd;
  // Latency-3 slave: three register stages
  always @(posedge clk) begin
    s1 <= (rd3 && addr3 == 32'h40) ? 32'h12345678 : 32'h0;
    s2 <= s1;
    s3 <= s2;
  end
  assign din3 = s3;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    tick;
    tick;
    check("rst_strobes", {30'h0, rd, wr}, 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_dout", dout, 32'h0);
    check("rst_ack_rsp", {28'h0, ack, rsp_valid}, 32'h0);
    check("rst_rspdata", rsp_data, 32'h0);
    rst = 1'b0;
    tick;
    req_addr = {32'h14, 32'h10};
    req_valid = 2'b01;
    tick;
    check("rd_ack", {30'h0, ack}, 32'h1);
    check("rd_strobe", {30'h0, rd, wr}, 32'h2);
    check("rd_addr", addr, 32'h10);
    check("rd_dout", dout, 32'h0);
    req_valid = 2'b00;
    tick;
    check("rd_wait_rd", {31'h0, rd}, 32'h0);
    check("rd_wait_addr", addr, 32'h10);
    check("rd_wait_rsp", {30'h0, rsp_valid}, 32'h0);
    tick;
    check("rd_rspvalid", {30'h0, rsp_valid}, 32'h1);
    check("rd_rspdata", rsp_data, 32'hCAFE0001);
    tick;
    check("rd_idle_rsp", {30'h0, rsp_valid}, 32'h0);
    check("rd_hold_data", rsp_data, 32'hCAFE0001);
    check("rd_idle_addr", addr, 32'h0);
    req_addr = {32'h20, 32'h10};
    req_data = {32'hDEADBEEF, 32'h0};
    req_write = 2'b10;
    req_valid = 2'b10;
    tick;
    check("wr_ack", {30'h0, ack}, 32'h2);
    check("wr_strobe", {30'h0, rd, wr}, 32'h1);
    check("wr_addr", addr, 32'h20);
    check("wr_dout", dout, 32'hDEADBEEF);
    check("wr_rsp", {30'h0, rsp_valid}, 32'h0);
    req_valid = 2'b00;
    req_write = 2'b00;
    tick;
    check("wr_idle_strobe", {30'h0, rd, wr}, 32'h0);
    check("wr_idle_addr", addr, 32'h0);
    check("wr_idle_dout", dout, 32'h0);
    check("wr_idle_rsp", {30'h0, rsp_valid}, 32'h0);
    req_addr = {32'h14, 32'h10};
    req_valid = 2'b11;
    for (int t = 0; t < 6; t++) begin
      tick;
      check("cont_ack", {30'h0, ack}, (t % 2 == 0) ? 32'h1 : 32'h2);
      check("cont_addr", addr, (t % 2 == 0) ? 32'h10 : 32'h14);
      tick;
      tick;
      check("cont_rspvalid", {30'h0, rsp_valid}, (t % 2 == 0) ? 32'h1 : 32'h2);
      check("cont_rspdata", rsp_data, (t % 2 == 0) ? 32'hCAFE0001 : 32'hCAFE0014);
      tick;
    end
    req_valid = 2'b00;
    req_valid3 = 2'b01;
    tick;
    check("l3_ack", {30'h0, ack3}, 32'h1);
    check("l3_rd", {31'h0, rd3}, 32'h1);
    check("l3_addr", addr3, 32'h40);
    req_valid3 = 2'b00;
    tick;
    check("l3_rd_once", {31'h0, rd3}, 32'h0);
    tick;
    tick;
    check("l3_early_rsp", {30'h0, rsp_valid3}, 32'h0);
    tick;
    check("l3_rspvalid", {30'h0, rsp_valid3}, 32'h1);
    check("l3_rspdata", rsp_data3, 32'h12345678);
    tick;
    check("l3_idle_rsp", {30'h0, rsp_valid3}, 32'h0);
    req_valid = 2'b01;
    tick;
    check("mr_ack", {30'h0, ack}, 32'h1);
    req_valid = 2'b00;
    tick;
    check("mr_in_wait", addr, 32'h10);
    rst = 1'b1;
    #1;
    check("mr_rst_addr", addr, 32'h0);
    check("mr_rst_strobes", {30'h0, rd, wr}, 32'h0);
    check("mr_rst_rspdata", rsp_data, 32'h0);
    check("mr_rst_ack_rsp", {28'h0, ack, rsp_valid}, 32'h0);
    tick;
    rst = 1'b0;
    tick;
    check("mr_no_rsp1", {30'h0, rsp_valid}, 32'h0);
    tick;
    check("mr_no_rsp2", {30'h0, rsp_valid}, 32'h0);
    req_valid = 2'b11;
    tick;
    check("mr_grant0", {30'h0, ack}, 32'h1);
    req_valid = 2'b00;
    tick;
    tick;
    check("mr_rspvalid", {30'h0, rsp_valid}, 32'h1);
    check("mr_rspdata", rsp_data, 32'hCAFE0001);
    tick;
    for (int c = 0; c < 20; c++) begin
      tick;
      check("idle_strobes", {28'h0, rd, wr, rsp_valid}, 32'h0);
      check("idle_addr_dout", addr | dout, 32'h0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
